// File: rtl/elevator_sequencer_if.sv
// Request, timer-handshake and status bundle between the car-motion
// sequencer and its surroundings (call buttons, run/door timers, display).
interface elevator_sequencer_if #(
  parameter int NFLOOR = 4,
  parameter int FW     = 2
);
  logic [NFLOOR-1:0] req;
  logic              endRun;
  logic              endOpen;
  logic              mv2nxt;
  logic              opendoor;
  logic [FW-1:0]     floor;
  logic              dir;
  logic [NFLOOR-1:0] pending;
  logic              busy;

  // Sequencer side: consumes calls and timer replies, drives commands/status
  modport master (
    input  req, endRun, endOpen,
    output mv2nxt, opendoor, floor, dir, pending, busy
  );

  // Environment side: call buttons, timers and display logic
  modport slave (
    output req, endRun, endOpen,
    input  mv2nxt, opendoor, floor, dir, pending, busy
  );
endinterface

// File: rtl/elevator_sequencer.sv
// Car-motion sequencer for a small elevator. Latches floor calls, serves them
// in SCAN order (keep going while work lies ahead, reverse only from rest),
// and initiates the run-timer and door-timer handshakes one floor at a time.
// Every output comes straight from a register.
module elevator_sequencer #(
  parameter int NFLOOR      = 4,
  parameter int FW          = 2,
  parameter int RESET_FLOOR = 0
) (
  input logic                  CP,
  input logic                  nCR,
  elevator_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STOP,
    OPEN,
    GAP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [NFLOOR-1:0] pending_q;
  logic [NFLOOR-1:0] pending_next;
  logic [FW-1:0]     floor_q;
  logic [FW-1:0]     floor_next;
  logic              dir_q;
  logic              dir_next;
  logic              mv_q;
  logic              mv_next;
  logic              od_q;
  logic              od_next;
  logic              busy_q;
  logic              above;
  logic              below;
  logic              here;
  logic              ahead;
  logic              behind;

  // Classify latched calls relative to the car: above it, below it, or at it
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NFLOOR; i++) begin
      if (pending_q[i] && (i > int'(floor_q))) above = 1'b1;
      if (pending_q[i] && (i < int'(floor_q))) below = 1'b1;
    end
    here   = pending_q[floor_q];
    ahead  = dir_q ? above : below;
    behind = dir_q ? below : above;
  end

  // Next state, floor, direction and command levels; commands default low so
  // the STOP and GAP cycles give each timer a visible low phase
  always_comb begin
    state_next = state;
    floor_next = floor_q;
    dir_next   = dir_q;
    mv_next    = 1'b0;
    od_next    = 1'b0;
    case (state)
      IDLE: begin
        if (here) begin
          state_next = OPEN;
          od_next    = 1'b1;
        end else if (ahead) begin
          state_next = RUN;
          mv_next    = 1'b1;
        end else if (behind) begin
          state_next = RUN;
          mv_next    = 1'b1;
          dir_next   = ~dir_q;
        end
      end
      RUN: begin
        if (bus.endRun) begin
          state_next = STOP;
          floor_next = dir_q ? (floor_q + FW'(1)) : (floor_q - FW'(1));
        end else begin
          mv_next = 1'b1;
        end
      end
      STOP: begin
        if (here) begin
          state_next = OPEN;
          od_next    = 1'b1;
        end else if (ahead) begin
          state_next = RUN;
          mv_next    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      OPEN: begin
        if (bus.endOpen) begin
          state_next = GAP;
        end else begin
          od_next = 1'b1;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Accumulate calls; the current floor's call is swallowed while the door is open
  always_comb begin
    pending_next = pending_q | bus.req;
    if ((state == OPEN) || (state_next == OPEN)) pending_next[floor_q] = 1'b0;
  end

  // State and output registers; reset drops both commands immediately
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state     <= IDLE;
      floor_q   <= FW'(RESET_FLOOR);
      dir_q     <= 1'b1;
      mv_q      <= 1'b0;
      od_q      <= 1'b0;
      pending_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      floor_q   <= floor_next;
      dir_q     <= dir_next;
      mv_q      <= mv_next;
      od_q      <= od_next;
      pending_q <= pending_next;
      busy_q    <= (state_next != IDLE);
    end
  end

  assign bus.mv2nxt   = mv_q;
  assign bus.opendoor = od_q;
  assign bus.floor    = floor_q;
  assign bus.dir      = dir_q;
  assign bus.pending  = pending_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_elevator_sequencer.sv
// Self-checking bench for elevator_sequencer: a cycle table for the basic
// sequences, hand-written corner-case sequences, and a randomized run checked
// against a SCAN-rule reference model that acts as both timers.
module tb_elevator_sequencer;

  logic CP;
  logic nCR;
  int   check_count;
  int   pass_count;

  elevator_sequencer_if #(.NFLOOR(4), .FW(2)) bus ();

  elevator_sequencer #(.NFLOOR(4), .FW(2), .RESET_FLOOR(0)) dut (
    .CP  (CP),
    .nCR (nCR),
    .bus (bus.master)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  typedef struct {
    logic [3:0] req;
    logic       er;
    logic       eo;
    logic       mv;
    logic       od;
    logic [1:0] fl;
    logic       dir;
    logic [3:0] pend;
    logic       busy;
  } vec_t;

  vec_t vecs [27];

  task automatic check_output(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic er, input logic eo);
    @(negedge CP);
    bus.req     = r;
    bus.endRun  = er;
    bus.endOpen = eo;
    @(posedge CP);
    #1;
    bus.req     = '0;
    bus.endRun  = 1'b0;
    bus.endOpen = 1'b0;
  endtask

  // Acts as the run timer (instant reply) until the door opens; fl = -1 on timeout
  task automatic serve_until_open(output int fl);
    fl = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge CP);
      bus.endRun = bus.mv2nxt;
      @(posedge CP);
      #1;
      bus.endRun = 1'b0;
      if (bus.opendoor) begin
        fl = int'(bus.floor);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CP);
    nCR = 1'b0;
    @(negedge CP);
    @(negedge CP);
    nCR = 1'b1;
  endtask

  function automatic bit work_toward(input logic [3:0] p, input int f, input bit d);
    for (int i = 0; i < 4; i++) begin
      if (p[i] && (d ? (i > f) : (i < f))) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    int         fl;
    logic [3:0] m_pending;
    logic [3:0] pend_old;
    logic [3:0] ri;
    int         m_floor;
    bit         m_dir;
    bit         stop_flag;
    bit         decision;
    bit         o_mv, o_od, o_busy;
    bit         eri, eoi;
    bit         exp_mv, exp_od, exp_busy, exp_dir;

    check_count = 0;
    pass_count  = 0;
    nCR         = 1'b0;
    bus.req     = '0;
    bus.endRun  = 1'b0;
    bus.endOpen = 1'b0;

    //            req     er    eo      mv    od    fl    dir   pend    busy
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0};
    vecs[1]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1};
    vecs[2]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1};
    vecs[3]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b1};
    vecs[4]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0};
    vecs[5]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b0};
    vecs[6]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1};
    vecs[7]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'b1000, 1'b1};
    vecs[8]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 4'b1000, 1'b1};
    vecs[9]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'b1000, 1'b1};
    vecs[10] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 4'b1000, 1'b1};
    vecs[11] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b1};
    vecs[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b1};
    vecs[13] = '{4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b1};
    vecs[14] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000, 1'b1};
    vecs[15] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000, 1'b0};
    vecs[16] = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000, 1'b0};
    vecs[17] = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0001, 1'b0};
    vecs[18] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0001, 1'b1};
    vecs[19] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0001, 1'b1};
    vecs[20] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0001, 1'b1};
    vecs[21] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0001, 1'b1};
    vecs[22] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0001, 1'b1};
    vecs[23] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b1};
    vecs[24] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1};
    vecs[25] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1};
    vecs[26] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};

    do_reset();
    #1;
    check_output("reset mv2nxt", int'(bus.mv2nxt), 0);
    check_output("reset opendoor", int'(bus.opendoor), 0);
    check_output("reset floor", int'(bus.floor), 0);
    check_output("reset dir", int'(bus.dir), 1);
    check_output("reset pending", int'(bus.pending), 0);
    check_output("reset busy", int'(bus.busy), 0);

    for (int i = 0; i < 27; i++) begin
      apply_stimulus(vecs[i].req, vecs[i].er, vecs[i].eo);
      check_output($sformatf("vec%0d mv2nxt", i), int'(bus.mv2nxt), int'(vecs[i].mv));
      check_output($sformatf("vec%0d opendoor", i), int'(bus.opendoor), int'(vecs[i].od));
      check_output($sformatf("vec%0d floor", i), int'(bus.floor), int'(vecs[i].fl));
      check_output($sformatf("vec%0d dir", i), int'(bus.dir), int'(vecs[i].dir));
      check_output($sformatf("vec%0d pending", i), int'(bus.pending), int'(vecs[i].pend));
      check_output($sformatf("vec%0d busy", i), int'(bus.busy), int'(vecs[i].busy));
    end

    // Car at floor 0 heading down; a call to 2 must reverse it and open at 2
    apply_stimulus(4'b0100, 1'b0, 1'b0);
    serve_until_open(fl);
    check_output("reach2 floor", fl, 2);
    check_output("reach2 dir", int'(bus.dir), 1);

    // Door open at 2: stray endRun plus a same-floor call are absorbed
    apply_stimulus(4'b0100, 1'b1, 1'b0);
    check_output("absorb floor", int'(bus.floor), 2);
    check_output("absorb opendoor", int'(bus.opendoor), 1);
    check_output("absorb mv2nxt", int'(bus.mv2nxt), 0);
    check_output("absorb pending", int'(bus.pending), 0);
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    check_output("gap opendoor", int'(bus.opendoor), 0);
    check_output("gap busy", int'(bus.busy), 1);
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    check_output("idle busy", int'(bus.busy), 0);
    check_output("idle pending", int'(bus.pending), 0);
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    check_output("no reopen", int'(bus.opendoor), 0);

    // Floor 2 heading up with calls at 1 and 3: visit 3 then 1
    apply_stimulus(4'b1010, 1'b0, 1'b0);
    check_output("scan pending", int'(bus.pending), 4'b1010);
    serve_until_open(fl);
    check_output("scan first stop", fl, 3);
    check_output("scan first pending", int'(bus.pending), 4'b0010);
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    serve_until_open(fl);
    check_output("scan second stop", fl, 1);
    check_output("scan second dir", int'(bus.dir), 0);
    check_output("scan second pending", int'(bus.pending), 0);

    // Reset asserted mid-run must drop mv2nxt without a clock edge
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    apply_stimulus(4'b1000, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    check_output("prerst mv2nxt", int'(bus.mv2nxt), 1);
    check_output("prerst floor", int'(bus.floor), 1);
    #2;
    nCR = 1'b0;
    #1;
    check_output("async mv2nxt", int'(bus.mv2nxt), 0);
    check_output("async opendoor", int'(bus.opendoor), 0);
    check_output("async floor", int'(bus.floor), 0);
    check_output("async dir", int'(bus.dir), 1);
    check_output("async pending", int'(bus.pending), 0);
    check_output("async busy", int'(bus.busy), 0);
    @(negedge CP);
    nCR = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(4'b0000, 1'b0, 1'b0);
      check_output($sformatf("postrst%0d cmd", i), int'({bus.mv2nxt, bus.opendoor, bus.busy}), 0);
    end

    // Randomized traffic; the bench plays both timers and tracks the SCAN rules
    do_reset();
    m_pending = '0;
    m_floor   = 0;
    m_dir     = 1'b1;
    stop_flag = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CP);
      o_mv   = bus.mv2nxt;
      o_od   = bus.opendoor;
      o_busy = bus.busy;
      ri     = '0;
      if ($urandom_range(0, 7) == 0) ri = 4'(1 << $urandom_range(0, 3));
      else if ($urandom_range(0, 40) == 0) ri = 4'($urandom_range(0, 15));
      eri = o_mv ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      eoi = o_od ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus.req     = ri;
      bus.endRun  = eri;
      bus.endOpen = eoi;
      @(posedge CP);
      #1;

      pend_old = m_pending;
      decision = !o_busy || stop_flag;
      if (o_mv && eri) m_floor = m_dir ? (m_floor + 1) : (m_floor - 1);
      exp_dir = m_dir;
      if (decision) begin
        if (pend_old[m_floor]) begin
          exp_mv = 1'b0; exp_od = 1'b1;
        end else if (work_toward(pend_old, m_floor, m_dir)) begin
          exp_mv = 1'b1; exp_od = 1'b0;
        end else if (!o_busy && work_toward(pend_old, m_floor, !m_dir)) begin
          exp_mv = 1'b1; exp_od = 1'b0; exp_dir = !m_dir;
        end else begin
          exp_mv = 1'b0; exp_od = 1'b0;
        end
        exp_busy = exp_mv | exp_od;
      end else if (o_mv) begin
        exp_mv = !eri; exp_od = 1'b0; exp_busy = 1'b1;
      end else if (o_od) begin
        exp_mv = 1'b0; exp_od = !eoi; exp_busy = 1'b1;
      end else begin
        exp_mv = 1'b0; exp_od = 1'b0; exp_busy = 1'b0;
      end
      m_dir = exp_dir;
      m_pending = pend_old | ri;
      if (o_od || exp_od) m_pending[m_floor] = 1'b0;
      stop_flag = o_mv && eri;

      check_output($sformatf("rand%0d mv2nxt", cyc), int'(bus.mv2nxt), int'(exp_mv));
      check_output($sformatf("rand%0d opendoor", cyc), int'(bus.opendoor), int'(exp_od));
      check_output($sformatf("rand%0d busy", cyc), int'(bus.busy), int'(exp_busy));
      check_output($sformatf("rand%0d dir", cyc), int'(bus.dir), int'(m_dir));
      check_output($sformatf("rand%0d floor", cyc), int'(bus.floor), m_floor);
      check_output($sformatf("rand%0d pending", cyc), int'(bus.pending), int'(m_pending));
    end
    bus.req     = '0;
    bus.endRun  = 1'b0;
    bus.endOpen = 1'b0;

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
